// File: rtl/pacman_pkg.sv
// Shared PS/2 keyboard scan codes, direction indices and receiver state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package pacman_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;

  localparam logic [7:0] SC_ARROW_UP = 8'h75;
  localparam logic [7:0] SC_ARROW_DN = 8'h72;
  localparam logic [7:0] SC_ARROW_LT = 8'h6B;
  localparam logic [7:0] SC_ARROW_RT = 8'h74;

  localparam logic [7:0] SC_KEY_W    = 8'h1D;
  localparam logic [7:0] SC_KEY_S    = 8'h1B;
  localparam logic [7:0] SC_KEY_A    = 8'h1C;
  localparam logic [7:0] SC_KEY_D    = 8'h23;

  // Index into held[3:0] = {up, down, left, right}
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic hit;
    dir_e dir;
  } dir_hit_t;

  function automatic dir_hit_t dir_lookup(input logic [7:0] code, input logic ext);
    dir_hit_t r;
    r.hit = 1'b1;
    r.dir = DIR_UP;
    if (ext) begin
      case (code)
        SC_ARROW_UP: r.dir = DIR_UP;
        SC_ARROW_DN: r.dir = DIR_DOWN;
        SC_ARROW_LT: r.dir = DIR_LEFT;
        SC_ARROW_RT: r.dir = DIR_RIGHT;
        default:     r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_KEY_W: r.dir = DIR_UP;
        SC_KEY_S: r.dir = DIR_DOWN;
        SC_KEY_A: r.dir = DIR_LEFT;
        SC_KEY_D: r.dir = DIR_RIGHT;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit frame FSM, odd parity, inter-edge timeout.
// byte_valid/frame_err one cycle after the stop-bit edge (or timeout); no backpressure, bytes are fire-and-forget.
module ps2_frame_rx
  import pacman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_dat,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_prev_q;
  logic             clk_s, dat_s, fall;

  rx_state_e        state_q, state_nxt;
  logic [7:0]       shreg_q, shreg_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic             par_ok_q, par_ok_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             vld_q, vld_nxt;
  logic             err_q, err_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s;

  always_comb begin
    state_nxt  = state_q;
    shreg_nxt  = shreg_q;
    idx_nxt    = idx_q;
    par_ok_nxt = par_ok_q;
    cnt_nxt    = '0;
    vld_nxt    = 1'b0;
    err_nxt    = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (fall && !dat_s) begin
          state_nxt = RX_DATA;
          idx_nxt   = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shreg_nxt = {dat_s, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            state_nxt = RX_PARITY;
          end else begin
            idx_nxt = idx_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_ok_nxt = ^{shreg_q, dat_s};
          state_nxt  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          vld_nxt   = dat_s & par_ok_q;
          err_nxt   = ~(dat_s & par_ok_q);
          state_nxt = RX_IDLE;
          idx_nxt   = 3'd0;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase

    // Inside a frame the counter runs between edges; reaching the limit abandons the frame.
    if (state_q != RX_IDLE && !fall) begin
      if (cnt_q == CNT_LAST) begin
        state_nxt = RX_IDLE;
        idx_nxt   = 3'd0;
        err_nxt   = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      par_ok_q <= 1'b0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      shreg_q  <= shreg_nxt;
      idx_q    <= idx_nxt;
      par_ok_q <= par_ok_nxt;
      cnt_q    <= cnt_nxt;
      vld_q    <= vld_nxt;
      err_q    <= err_nxt;
    end
  end

  assign byte_dat   = shreg_q;
  assign byte_valid = vld_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow/WASD decoder: E0/F0 prefix tracking, direction pulses and held-key levels.
// Pulse/held update two cycles after the stop-bit edge; no backpressure, every byte is acted on immediately.
module ps2_arrow_decoder
  import pacman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;

  logic       ext_q, brk_q;
  logic [3:0] pulse_q, held_q;
  dir_hit_t   lk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .byte_dat  (rx_byte),
    .byte_valid(rx_vld),
    .frame_err (rx_err)
  );

  assign lk = dir_lookup(rx_byte, ext_q);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      pulse_q <= '0;
      held_q  <= '0;
    end else begin
      pulse_q <= '0;
      // A discarded frame may have been a prefix; drop it so it cannot bind to the next code.
      if (rx_err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_vld) begin
        if (rx_byte == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk_q <= 1'b1;
        end else begin
          if (lk.hit) begin
            if (brk_q) begin
              held_q[lk.dir] <= 1'b0;
            end else begin
              pulse_q[lk.dir] <= 1'b1;
              held_q[lk.dir]  <= 1'b1;
            end
          end
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  assign up        = pulse_q[DIR_UP];
  assign down      = pulse_q[DIR_DOWN];
  assign left      = pulse_q[DIR_LEFT];
  assign right     = pulse_q[DIR_RIGHT];
  assign held      = held_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Bench for ps2_arrow_decoder: directed key sequences plus random frames against a frame-level model.
module tb_ps2_arrow_decoder;

  localparam int TO = 200;

  localparam logic [7:0] EXT_MAP [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  localparam logic [7:0] STD_MAP [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  localparam logic [7:0] CODES   [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       up, down, left, right, frame_err;
  logic [3:0] held;

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .held     (held),
    .frame_err(frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         due;
    bit         is_err;
    logic [7:0] b;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   printed = 0;
  int   last_fall = 0;

  logic [3:0] m_held = 4'b0;
  bit         m_ext = 0, m_brk = 0;
  logic [3:0] exp_pulse;
  logic       exp_ferr;

  int n_up, n_down, n_left, n_right, n_ferr;
  int up_cyc, ferr_cyc;

  function automatic int map_dir(input logic [7:0] b, input bit e);
    for (int i = 0; i < 4; i++)
      if ((e && b == EXT_MAP[i]) || (!e && b == STD_MAP[i])) return 3 - i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clr_counts();
    n_up = 0; n_down = 0; n_left = 0; n_right = 0; n_ferr = 0;
    up_cyc = -1; ferr_cyc = -1;
  endtask

  // Per-cycle compare against the frame-level model.
  initial begin
    int d;
    forever begin
      @(posedge CLOCK_50);
      cyc++;
      #1;
      exp_pulse = 4'b0;
      exp_ferr  = 1'b0;
      if (reset) begin
        m_held = 4'b0; m_ext = 0; m_brk = 0;
        evq.delete();
      end else begin
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].due == cyc) begin
            if (evq[i].is_err) begin
              exp_ferr = 1'b1;
              m_ext = 0; m_brk = 0;
            end else if (evq[i].b == 8'hE0) begin
              m_ext = 1;
            end else if (evq[i].b == 8'hF0) begin
              m_brk = 1;
            end else begin
              d = map_dir(evq[i].b, m_ext);
              if (d >= 0) begin
                if (m_brk) m_held[d] = 1'b0;
                else begin
                  m_held[d] = 1'b1;
                  exp_pulse[d] = 1'b1;
                end
              end
              m_ext = 0; m_brk = 0;
            end
            evq.delete(i);
          end
        end
      end
      checks++;
      if ({up, down, left, right} !== exp_pulse || held !== m_held || frame_err !== exp_ferr) begin
        errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL cycle %0d: pulses=%b held=%b frame_err=%b, expected pulses=%b held=%b frame_err=%b",
                   cyc, {up, down, left, right}, held, frame_err, exp_pulse, m_held, exp_ferr);
        end
      end
      if (up)    begin n_up++; up_cyc = cyc; end
      if (down)  n_down++;
      if (left)  n_left++;
      if (right) n_right++;
      if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
    end
  end

  initial begin
    repeat (95000) @(posedge CLOCK_50);
    $display("FAIL watchdog: cycle budget expired at %0d", cyc);
    $fatal(1, "watchdog");
  end

  // nedges < 11 truncates the frame after that many falling edges.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nedges);
    logic [10:0] bits;
    int h;
    ev_t ev;
    h = $urandom_range(5, 15);
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = bits[i];
      repeat (h) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      last_fall = cyc;
      if (i == nedges - 1) begin
        ev.b = b;
        if (nedges < 11) begin
          ev.is_err = 1; ev.due = cyc + 3 + TO;
        end else if (bad_par || bad_stop) begin
          ev.is_err = 1; ev.due = cyc + 3;
        end else begin
          ev.is_err = 0; ev.due = cyc + 4;
        end
        evq.push_back(ev);
      end
      repeat (h) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    if (nedges < 11) repeat (TO + 10) @(negedge CLOCK_50);
    repeat ($urandom_range(5, 40)) @(negedge CLOCK_50);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 0, 0, 11);
  endtask

  initial begin
    int stop_c;
    int r;
    logic [7:0] code;
    clr_counts();
    repeat (6) @(negedge CLOCK_50);
    check("reset_held", held, 4'b0000);
    check("reset_pulses", {up, down, left, right, frame_err}, 5'b0);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    // Extended up make
    clr_counts();
    send_byte(8'hE0);
    send_byte(8'h75);
    stop_c = last_fall;
    repeat (10) @(negedge CLOCK_50);
    check("up_make_count", n_up, 1);
    check("up_make_cycle", up_cyc, stop_c + 4);
    check("up_make_held", held, 4'b1000);

    // Extended up break
    clr_counts();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    repeat (10) @(negedge CLOCK_50);
    check("up_break_count", n_up, 0);
    check("up_break_held", held, 4'b0000);

    // Bad parity then good A
    clr_counts();
    send_frame(8'h1C, 1, 0, 11);
    repeat (10) @(negedge CLOCK_50);
    check("badpar_ferr", n_ferr, 1);
    check("badpar_left", n_left, 0);
    check("badpar_held", held, 4'b0000);
    send_byte(8'h1C);
    repeat (10) @(negedge CLOCK_50);
    check("goodA_left", n_left, 1);
    check("goodA_held", held, 4'b0010);

    // Release A, then a timed-out frame, then extended right
    send_byte(8'hF0);
    send_byte(8'h1C);
    clr_counts();
    send_frame(8'h5A, 0, 0, 5);
    stop_c = last_fall;
    check("timeout_ferr", n_ferr, 1);
    check("timeout_cycle", ferr_cyc, stop_c + 3 + TO);
    send_byte(8'hE0);
    send_byte(8'h74);
    repeat (10) @(negedge CLOCK_50);
    check("after_to_held", held, 4'b0001);

    // W plus extended left, then reset mid-frame
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    send_byte(8'h1D);
    send_byte(8'hE0);
    send_byte(8'h6B);
    repeat (10) @(negedge CLOCK_50);
    check("two_held", held, 4'b1010);
    clr_counts();
    code = 8'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = (i == 0) ? 1'b0 : code[i-1];
      repeat (8) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    @(negedge CLOCK_50);
    reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("midreset_held", held, 4'b0000);
    check("midreset_pulses", {up, down, left, right, frame_err}, 5'b0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (TO + 20) @(negedge CLOCK_50);
    check("midreset_ferr", n_ferr, 0);
    send_byte(8'h23);
    repeat (10) @(negedge CLOCK_50);
    check("after_reset_right", n_right, 1);
    check("after_reset_held", held, 4'b0001);

    // Random traffic
    for (int k = 0; k < 70; k++) begin
      r = $urandom_range(0, 99);
      if (r < 75) code = CODES[$urandom_range(0, 9)];
      else        code = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 99);
      if (r < 5)       send_frame(code, 0, 0, $urandom_range(1, 10));
      else if (r < 10) send_frame(code, 1, 0, 11);
      else if (r < 14) send_frame(code, 0, 1, 11);
      else             send_byte(code);
    end

    repeat (50) @(negedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_arrow_decoder.md
PS2_ARROW_DECODER -- requirements
Module: ps2_arrow_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, max CLOCK_50 cycles between PS2_CLK falling edges inside a frame (1 ms).
REQ-002 SHALL have port CLOCK_50 input 1: the only clock.
REQ-003 SHALL have port reset input 1: synchronous, active-high reset.
REQ-004 SHALL have port PS2_CLK input 1: raw keyboard clock, asynchronous.
REQ-005 SHALL have port PS2_DAT input 1: raw keyboard data, asynchronous.
REQ-006 SHALL have ports up, down, left, right output 1 each: one-cycle pulse per make code of that direction.
REQ-007 SHALL have port held output 4: level, {up,down,left,right} keys currently pressed.
REQ-008 SHALL have port frame_err output 1: one-cycle pulse per discarded frame.

Function
REQ-009 SHALL pass PS2_CLK and PS2_DAT through 2-flop synchronizers; a falling edge is synchronized clock 1 in cycle T-1 and 0 in cycle T.
REQ-010 SHALL use frame receiver states IDLE, DATA, PARITY, STOP.
REQ-011 IDLE: on an edge with data 0 (start bit), go to DATA with bit index 0; on an edge with data 1, stay in IDLE with no error.
REQ-012 DATA: shift 8 bits LSB first on successive edges, then go to PARITY.
REQ-013 PARITY: sample the parity bit; the 8 data bits plus parity SHALL have odd weight, otherwise the frame is marked bad; go to STOP.
REQ-014 STOP: sample the stop bit; stop=1 with good parity gives byte_valid the next cycle; stop=0 or bad parity pulses frame_err; return to IDLE in both cases.
REQ-015 Timeout: in DATA, PARITY or STOP, TIMEOUT_CYCLES cycles without an edge SHALL return the receiver to IDLE, pulse frame_err, and clear the ext and brk flags; the counter saturates and resets on every edge.
REQ-016 Decoder, on byte_valid:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte is looked up, then clears ext and brk.
REQ-017 Direction map:
  - ext=1: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - ext=0: 0x1D up, 0x1B down, 0x1C left, 0x23 right.
  - Any other code has no effect besides clearing the flags.
REQ-018 On a mapped make (brk=0), the matching direction output SHALL pulse and its held bit SHALL set.
REQ-019 On a mapped break (brk=1), no pulse SHALL occur and the held bit SHALL clear.
REQ-020 Latency: stop-bit edge in cycle T → byte_valid in T+1 → pulse/held update in T+2.
REQ-021 Repeated makes (typematic) SHALL pulse again each time; held stays 1.
REQ-022 Multiple held bits MAY be 1 simultaneously; at most one direction pulse per cycle.
REQ-023 frame_err SHALL clear ext and brk, so a corrupted prefix never modifies the next byte.
REQ-024 Arrow and WASD for the same direction share one held bit; a break of either clears it.

Reset
REQ-025 While reset=1 the block SHALL hold:
  - Receiver in IDLE; shift register, bit index and timeout counter 0.
  - ext and brk cleared.
  - Synchronizer flops set to 1.
  - held=4'b0000, up/down/left/right=0, frame_err=0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame with no frame_err; the next valid start bit is received normally.

Structure
REQ-027 Scan-code constants (E0, F0, eight direction codes) and the direction index enum SHALL live in the shared package pacman_pkg.
REQ-028 Synchronizers, edge detect, frame FSM, parity and timeout SHALL be one sub-module ps2_frame_rx, outputting byte[7:0], byte_valid and frame_err.
REQ-029 The make/break decoder SHALL be in the top of ps2_arrow_decoder.

Verification
REQ-030 Frames E0,75 at 10 kHz: up pulses once at stop edge T+2; held=4'b1000.
REQ-031 Frames E0,F0,75 after REQ-030: no pulse; held=4'b0000.
REQ-032 Frame 0x1C with wrong parity: frame_err pulses; no left pulse; held unchanged. Next good 0x1C: left pulses, held=4'b0010.
REQ-033 Send the start bit plus 4 data bits, then idle 50000 cycles: frame_err pulses at cycle 50000; the following E0,74 sets held=4'b0001.
REQ-034 Make 0x1D, then E0,6B: held=4'b1010. Then reset mid-frame of the next byte: all outputs 0 and no frame_err. After release, 0x23 pulses right.
